// File: rtl/microwave_pkg.sv
// ---------------------------------------------------------------------------
// microwave_pkg
// Shared types and constants for the microwave front panel blocks.
//   entry_state_t : keypad time-entry FSM states
//   BCD_DIGITS    : digits in the MM:SS entry buffer
//   MAX_DIGIT     : largest valid encoded key value
//   MAX_SECONDS   : largest second count the buffer can express (99:99)
// ---------------------------------------------------------------------------
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        LOAD   = 2'd2,
        LOCKED = 2'd3
    } entry_state_t;

    localparam int BCD_DIGITS  = 4;
    localparam int MAX_DIGIT   = 9;
    localparam int MAX_SECONDS = 6039;

endpackage

// File: rtl/bcd_time_to_seconds.sv
// ---------------------------------------------------------------------------
// bcd_time_to_seconds
// Combinational conversion of a 4-digit BCD MM:SS value to binary seconds.
// The seconds field is not normalised, so s10 may be 6..9.
//   bcd     : {m10, m1, s10, s1}, s1 in bits [3:0]
//   seconds : (m10*10 + m1)*60 + (s10*10 + s1)
// ---------------------------------------------------------------------------
module bcd_time_to_seconds
    import microwave_pkg::*;
#(
    parameter int SEC_W = 13
) (
    input  logic [15:0]      bcd,
    output logic [SEC_W-1:0] seconds
);

    logic [SEC_W-1:0] m10;
    logic [SEC_W-1:0] m1;
    logic [SEC_W-1:0] s10;
    logic [SEC_W-1:0] s1;
    logic [SEC_W-1:0] minutes;
    logic [SEC_W-1:0] secs_field;

    assign m10 = SEC_W'(bcd[15:12]);
    assign m1  = SEC_W'(bcd[11:8]);
    assign s10 = SEC_W'(bcd[7:4]);
    assign s1  = SEC_W'(bcd[3:0]);

    // x*10 = x*8 + x*2
    assign minutes    = (m10 << 3) + (m10 << 1) + m1;
    assign secs_field = (s10 << 3) + (s10 << 1) + s1;

    // x*60 = x*32 + x*16 + x*8 + x*4; max result 6039 fits in 13 bits
    assign seconds = (minutes << 5) + (minutes << 4) + (minutes << 3)
                   + (minutes << 2) + secs_field;

endmodule

// File: rtl/keypad_time_entry.sv
// ---------------------------------------------------------------------------
// keypad_time_entry
// Collects key presses into a 4-digit BCD MM:SS buffer, converts it to a
// binary second count on START, pulses load to the cooking timer and then
// locks entry until the timer reports done.
//   clk, rst_n     : clock, synchronous active-low reset
//   enable         : when low, digit/start/clear events are ignored
//   encoded        : encoded key value, 0..9 valid
//   key_valid      : a digit key is held
//   start_key      : START level
//   clear_key      : CLEAR level
//   done           : cook cycle finished pulse
//   digits         : BCD buffer {m10, m1, s10, s1}
//   digit_count    : digits entered, 0..4
//   total_seconds  : registered binary second count
//   load           : one-cycle pulse, total_seconds valid alongside
//   locked         : entry locked while cooking
// ---------------------------------------------------------------------------
module keypad_time_entry
    import microwave_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SEC_W      = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [3:0]              encoded,
    input  logic                    key_valid,
    input  logic                    start_key,
    input  logic                    clear_key,
    input  logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [2:0]              digit_count,
    output logic [SEC_W-1:0]        total_seconds,
    output logic                    load,
    output logic                    locked
);

    entry_state_t state, state_d;

    logic                    key_q;
    logic                    start_q;
    logic                    clear_q;
    logic                    digit_ev;
    logic                    start_ev;
    logic                    clear_ev;
    logic [4*NUM_DIGITS-1:0] digits_d;
    logic [2:0]              count_d;
    logic [SEC_W-1:0]        secs_d;
    logic [SEC_W-1:0]        converted;

    // Rising-edge events; enable only gates the events, the edge registers
    // keep tracking the inputs so a key held while disabled or locked never
    // fires later.
    assign digit_ev = enable & key_valid & ~key_q & (encoded <= 4'(MAX_DIGIT));
    assign start_ev = enable & start_key & ~start_q;
    assign clear_ev = enable & clear_key & ~clear_q;

    bcd_time_to_seconds #(
        .SEC_W (SEC_W)
    ) u_convert (
        .bcd     (digits[15:0]),
        .seconds (converted)
    );

    // Next-state and next-value logic. Within ENTRY the order of the if
    // chain gives clear priority over start, and start over a digit.
    always_comb begin
        state_d  = state;
        digits_d = digits;
        count_d  = digit_count;
        secs_d   = total_seconds;

        case (state)
            IDLE: begin
                if (digit_ev) begin
                    digits_d      = '0;
                    digits_d[3:0] = encoded;
                    count_d       = 3'd1;
                    state_d       = ENTRY;
                end
            end

            ENTRY: begin
                if (clear_ev) begin
                    digits_d = '0;
                    count_d  = 3'd0;
                    state_d  = IDLE;
                end else if (start_ev) begin
                    secs_d  = converted;
                    state_d = LOAD;
                end else if (digit_ev && (digit_count < 3'(NUM_DIGITS))) begin
                    digits_d = {digits[4*NUM_DIGITS-5:0], encoded};
                    count_d  = digit_count + 3'd1;
                end
            end

            LOAD: begin
                state_d = LOCKED;
            end

            LOCKED: begin
                if (done) begin
                    digits_d = '0;
                    count_d  = 3'd0;
                    secs_d   = '0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, buffer and edge registers. load and locked are decoded from the
    // next state so they are flops aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            digits        <= '0;
            digit_count   <= 3'd0;
            total_seconds <= '0;
            load          <= 1'b0;
            locked        <= 1'b0;
            key_q         <= 1'b0;
            start_q       <= 1'b0;
            clear_q       <= 1'b0;
        end else begin
            state         <= state_d;
            digits        <= digits_d;
            digit_count   <= count_d;
            total_seconds <= secs_d;
            load          <= (state_d == LOAD);
            locked        <= (state_d == LOCKED);
            key_q         <= key_valid;
            start_q       <= start_key;
            clear_q       <= clear_key;
        end
    end

endmodule
